// File: rtl/seed_expand_window_pkg.sv
// Shared constants, state encoding and helpers for the WOTS seed expander
// and the PRF message packer.
package seed_expand_window_pkg;

    localparam int unsigned MSG_W   = 1024;
    localparam int unsigned FIELD_W = 256;

    // Bit offsets of the four 256-bit fields of a two-block PRF/F/H message
    localparam int unsigned PAD_LSB = 768;
    localparam int unsigned KEY_LSB = 512;
    localparam int unsigned IDX_LSB = 256;
    localparam int unsigned SHA_LSB = 0;

    // Domain-separation values placed in the leading 256-bit field
    localparam int unsigned PAD_F   = 0;
    localparam int unsigned PAD_H   = 1;
    localparam int unsigned PAD_PRF = 3;

    // SHA-256 trailer for a 768-bit message: 0x80 marker, length 0x300
    localparam logic [FIELD_W-1:0] SHA_PAD_768 = {8'h80, 184'h0, 64'h300};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seed_expand_window_prf_msg_build.sv
// Packs pad constant, key and zero-extended index into the 1024-bit
// two-block SHA-256 message; purely combinational.
module seed_expand_window_prf_msg_build
    import seed_expand_window_pkg::*;
#(
    parameter int unsigned KEY_LEN = 256,
    parameter int unsigned IDX_W   = 32,
    parameter int unsigned PAD     = PAD_PRF
) (
    input  logic [KEY_LEN-1:0] key,
    input  logic [IDX_W-1:0]   index,
    output logic [MSG_W-1:0]   msg_c
);

    always_comb begin
        msg_c                      = '0;
        msg_c[PAD_LSB +: FIELD_W]  = FIELD_W'(PAD);
        msg_c[KEY_LSB +: FIELD_W]  = FIELD_W'(key);
        msg_c[IDX_LSB +: FIELD_W]  = FIELD_W'(index);
        msg_c[SHA_LSB +: FIELD_W]  = SHA_PAD_768;
    end

endmodule

// File: rtl/seed_expand_window.sv
// Expands WOTS secret seeds PRF(key, i) for a runtime index window, driving the
// shared SHA-256 wrapper with midstate caching and writing seeds to local memory.
module seed_expand_window
    import seed_expand_window_pkg::*;
#(
    parameter int unsigned SEED_NUM              = 67,
    parameter int unsigned KEY_LEN               = 256,
    parameter int unsigned XMSS_HASH_PADDING_PRF = PAD_PRF,
    parameter int unsigned IDX_W                 = 32,
    localparam int unsigned CNT_W                = clog2(SEED_NUM + 1),
    localparam int unsigned ADDR_W               = clog2(SEED_NUM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [KEY_LEN-1:0] input_key,
    input  logic [IDX_W-1:0]   base_index,
    input  logic [CNT_W-1:0]   seed_count,
    output logic               busy,
    output logic               done,
    output logic               hash_start,
    output logic [MSG_W-1:0]   hash_data_in,
    output logic               message_length,
    output logic               store_intermediate,
    output logic               continue_intermediate,
    input  logic               hash_done,
    input  logic [KEY_LEN-1:0] hash_data_out,
    output logic [KEY_LEN-1:0] seed_wr_data,
    output logic [ADDR_W-1:0]  seed_mem_wr_addr,
    output logic               seed_mem_wr_en,
    input  logic               seed_mem_wr_ready
);

    state_t               state;
    state_t               state_nxt;
    logic [KEY_LEN-1:0]   key_q;
    logic [KEY_LEN-1:0]   key_nxt;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_nxt;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [CNT_W-1:0]     total_q;
    logic [CNT_W-1:0]     total_nxt;
    logic                 first_q;
    logic                 first_nxt;
    logic [KEY_LEN-1:0]   data_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic                 hash_start_nxt;
    logic                 store_nxt;
    logic                 cont_nxt;
    logic                 wr_en_nxt;

    assign message_length   = 1'b1;
    assign seed_mem_wr_addr = ADDR_W'(cnt_q);

    seed_expand_window_prf_msg_build #(
        .KEY_LEN (KEY_LEN),
        .IDX_W   (IDX_W),
        .PAD     (XMSS_HASH_PADDING_PRF)
    ) u_msg_build (
        .key   (key_q),
        .index (idx_q),
        .msg_c (hash_data_in)
    );

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt = state;
        key_nxt   = key_q;
        idx_nxt   = idx_q;
        cnt_nxt   = cnt_q;
        total_nxt = total_q;
        first_nxt = first_q;
        data_nxt  = seed_wr_data;

        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_nxt   = input_key;
                        idx_nxt   = base_index;
                        total_nxt = seed_count;
                        cnt_nxt   = '0;
                        first_nxt = 1'b1;
                        state_nxt = (seed_count == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (hash_done) begin
                        data_nxt  = hash_data_out;
                        state_nxt = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (seed_mem_wr_ready) begin
                        cnt_nxt   = cnt_q + CNT_W'(1);
                        idx_nxt   = idx_q + IDX_W'(1);
                        first_nxt = 1'b0;
                        state_nxt = ((cnt_q + CNT_W'(1)) == total_q) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Outputs are registered copies of what the next state implies
        busy_nxt       = (state_nxt != ST_IDLE);
        done_nxt       = (state_nxt == ST_DONE);
        hash_start_nxt = (state_nxt == ST_ISSUE);
        store_nxt      = ((state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT)) && first_nxt;
        cont_nxt       = ((state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT)) && !first_nxt;
        wr_en_nxt      = (state_nxt == ST_WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= ST_IDLE;
            key_q                 <= '0;
            idx_q                 <= '0;
            cnt_q                 <= '0;
            total_q               <= '0;
            first_q               <= 1'b0;
            seed_wr_data          <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            hash_start            <= 1'b0;
            store_intermediate    <= 1'b0;
            continue_intermediate <= 1'b0;
            seed_mem_wr_en        <= 1'b0;
        end else begin
            state                 <= state_nxt;
            key_q                 <= key_nxt;
            idx_q                 <= idx_nxt;
            cnt_q                 <= cnt_nxt;
            total_q               <= total_nxt;
            first_q               <= first_nxt;
            seed_wr_data          <= data_nxt;
            busy                  <= busy_nxt;
            done                  <= done_nxt;
            hash_start            <= hash_start_nxt;
            store_intermediate    <= store_nxt;
            continue_intermediate <= cont_nxt;
            seed_mem_wr_en        <= wr_en_nxt;
        end
    end

endmodule

// File: tb/tb_seed_expand_window.sv
// Directed bench for seed_expand_window with a behavioural hash wrapper and seed memory.
module tb_seed_expand_window;

    localparam int SEED_NUM = 67;
    localparam int LAT      = 4;
    localparam int EXTRA    = 3;
    localparam logic [255:0] EXP_SHA = {8'h80, 184'h0, 64'h300};
    localparam logic [255:0] SENT    = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] K1 = 256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [255:0] K2 = 256'hcafef00d_11223344_55667788_99aabbcc_ddeeff00_a1b2c3d4_e5f60718_293a4b5c;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [255:0] input_key = '0;
    logic [31:0]  base_index = '0;
    logic [6:0]   seed_count = '0;
    logic         busy;
    logic         done;
    logic         hash_start;
    logic [1023:0] hash_data_in;
    logic         message_length;
    logic         store_intermediate;
    logic         continue_intermediate;
    logic         hash_done = 1'b0;
    logic [255:0] hash_data_out = '0;
    logic [255:0] seed_wr_data;
    logic [6:0]   seed_mem_wr_addr;
    logic         seed_mem_wr_en;
    logic         seed_mem_wr_ready = 1'b1;

    int total = 0;
    int bad = 0;

    seed_expand_window dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .abort                 (abort),
        .input_key             (input_key),
        .base_index            (base_index),
        .seed_count            (seed_count),
        .busy                  (busy),
        .done                  (done),
        .hash_start            (hash_start),
        .hash_data_in          (hash_data_in),
        .message_length        (message_length),
        .store_intermediate    (store_intermediate),
        .continue_intermediate (continue_intermediate),
        .hash_done             (hash_done),
        .hash_data_out         (hash_data_out),
        .seed_wr_data          (seed_wr_data),
        .seed_mem_wr_addr      (seed_mem_wr_addr),
        .seed_mem_wr_en        (seed_mem_wr_en),
        .seed_mem_wr_ready     (seed_mem_wr_ready)
    );

    always #5 clk = ~clk;

    // Stand-in digest: depends on key and index so misrouted fields show up
    function automatic logic [255:0] fake(input logic [255:0] k, input logic [31:0] i);
        return k ^ {8{i ^ 32'h9E37_79B9}};
    endfunction

    logic [255:0] mem [0:SEED_NUM-1];
    logic [31:0]  idx_log [$];
    logic         store_log [$];
    int n_hs = 0, n_store = 0, n_cont = 0, n_done = 0, n_wr = 0, hdr_bad = 0;
    int cd = 0, stall_addr = -1, stall_left = 0, stall_cycles = 0, stall_bad = 0;
    logic [255:0] pend = '0;
    logic [255:0] stall_data = '0;

    // Hash wrapper, write-ready driver and seed memory, all on the falling edge
    initial forever begin
        @(negedge clk);
        hash_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                hash_done     = 1'b1;
                hash_data_out = pend;
            end
        end
        if (hash_start === 1'b1) begin
            n_hs++;
            if (store_intermediate === 1'b1) n_store++;
            if (continue_intermediate === 1'b1) n_cont++;
            if (hash_data_in[1023:768] !== 256'd3 || hash_data_in[511:288] !== '0 ||
                hash_data_in[255:0] !== EXP_SHA || message_length !== 1'b1 ||
                (store_intermediate ^ continue_intermediate) !== 1'b1)
                hdr_bad++;
            idx_log.push_back(hash_data_in[287:256]);
            store_log.push_back(store_intermediate);
            pend = fake(hash_data_in[767:512], hash_data_in[287:256]);
            cd   = (store_intermediate === 1'b1) ? LAT + EXTRA : LAT;
        end
        seed_mem_wr_ready = 1'b1;
        if (seed_mem_wr_en === 1'b1 && int'(seed_mem_wr_addr) == stall_addr) begin
            if (stall_cycles == 0) stall_data = seed_wr_data;
            else if (seed_wr_data !== stall_data) stall_bad++;
            stall_cycles++;
            if (stall_left > 0) begin
                seed_mem_wr_ready = 1'b0;
                stall_left--;
            end
        end
        if (seed_mem_wr_en === 1'b1 && seed_mem_wr_ready === 1'b1) begin
            mem[seed_mem_wr_addr] = seed_wr_data;
            n_wr++;
        end
        if (done === 1'b1) n_done++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_run();
        @(posedge clk);
        for (int i = 0; i < SEED_NUM; i++) mem[i] = SENT;
        idx_log.delete();
        store_log.delete();
        n_hs = 0; n_store = 0; n_cont = 0; n_done = 0; n_wr = 0; hdr_bad = 0;
    endtask

    task automatic pulse_start(input logic [255:0] k, input logic [31:0] b, input logic [6:0] c);
        @(negedge clk);
        input_key  = k;
        base_index = b;
        seed_count = c;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            if (n_done > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (hash_start !== 1'b0) begin bad++; $display("FAIL reset_hash_start got=%0b exp=0", hash_start); end
        total++; if (message_length !== 1'b1) begin bad++; $display("FAIL reset_msg_len got=%0b exp=1", message_length); end
        total++; if ({store_intermediate, continue_intermediate, seed_mem_wr_en} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {store_intermediate, continue_intermediate, seed_mem_wr_en}); end
        total++; if (seed_wr_data !== '0 || seed_mem_wr_addr !== '0) begin
            bad++; $display("FAIL reset_wr got=%h/%0d exp=0/0", seed_wr_data, seed_mem_wr_addr); end
        total++; if (hash_data_in !== {256'd3, 256'd0, 256'd0, EXP_SHA}) begin
            bad++; $display("FAIL reset_msg got=%h", hash_data_in); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_run();
        bit ok;
        clear_run();
        pulse_start(K1, 32'd0, 7'd67);
        wait_done(3000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL full_timeout got=%0b exp=1", ok); end
        total++; if (n_wr !== 67) begin bad++; $display("FAIL full_writes got=%0d exp=67", n_wr); end
        for (int i = 0; i < 67; i++) begin
            total++; if (mem[i] !== fake(K1, 32'(i))) begin bad++; $display("FAIL full_mem[%0d] got=%h exp=%h", i, mem[i], fake(K1, 32'(i))); end
        end
        total++; if (n_hs !== 67 || n_store !== 1 || n_cont !== 66) begin
            bad++; $display("FAIL full_hash_counts got=%0d/%0d/%0d exp=67/1/66", n_hs, n_store, n_cont); end
        total++; if (store_log.size() == 0 || store_log[0] !== 1'b1) begin bad++; $display("FAIL full_first_store got=0 exp=1"); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL full_done_count got=%0d exp=1", n_done); end
        total++; if (hdr_bad !== 0) begin bad++; $display("FAIL full_header got=%0d exp=0", hdr_bad); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_after got=%0b exp=0", busy); end
    endtask

    task automatic test_window();
        bit ok;
        clear_run();
        pulse_start(K2, 32'd60, 7'd5);
        repeat (3) @(posedge clk);
        pulse_start(K1, 32'd0, 7'd2);
        wait_done(500, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL win_timeout got=%0b exp=1", ok); end
        total++; if (idx_log.size() !== 5) begin bad++; $display("FAIL win_hash_count got=%0d exp=5", idx_log.size()); end
        for (int i = 0; i < 5; i++) begin
            total++; if (i < idx_log.size() && idx_log[i] !== 32'(60 + i)) begin
                bad++; $display("FAIL win_idx[%0d] got=%0d exp=%0d", i, idx_log[i], 60 + i); end
            total++; if (mem[i] !== fake(K2, 32'(60 + i))) begin bad++; $display("FAIL win_mem[%0d] got=%h", i, mem[i]); end
        end
        total++; if (mem[5] !== SENT) begin bad++; $display("FAIL win_mem5 got=%h exp=%h", mem[5], SENT); end
        total++; if (n_done !== 1 || hdr_bad !== 0) begin bad++; $display("FAIL win_done_hdr got=%0d/%0d exp=1/0", n_done, hdr_bad); end
    endtask

    task automatic test_zero_count();
        clear_run();
        @(negedge clk);
        seed_count = 7'd0;
        base_index = 32'd9;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        total++; if ({done, busy} !== 2'b11) begin bad++; $display("FAIL zero_first got=%b exp=11", {done, busy}); end
        @(negedge clk);
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL zero_second got=%b exp=00", {done, busy}); end
        repeat (4) @(posedge clk);
        total++; if (n_hs !== 0 || n_done !== 1) begin bad++; $display("FAIL zero_counts got=%0d/%0d exp=0/1", n_hs, n_done); end
    endtask

    task automatic test_stall();
        bit ok;
        clear_run();
        stall_addr = 2; stall_left = 7; stall_cycles = 0; stall_bad = 0;
        pulse_start(K1, 32'd0, 7'd5);
        wait_done(500, ok);
        stall_addr = -1;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_timeout got=%0b exp=1", ok); end
        total++; if (stall_cycles !== 8) begin bad++; $display("FAIL stall_cycles got=%0d exp=8", stall_cycles); end
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL stall_data_stable got=%0d exp=0", stall_bad); end
        total++; if (n_hs !== 5 || n_wr !== 5) begin bad++; $display("FAIL stall_counts got=%0d/%0d exp=5/5", n_hs, n_wr); end
        for (int i = 0; i < 5; i++) begin
            total++; if (mem[i] !== fake(K1, 32'(i))) begin bad++; $display("FAIL stall_mem[%0d] got=%h", i, mem[i]); end
        end
    endtask

    task automatic test_abort();
        bit ok;
        clear_run();
        pulse_start(K1, 32'd0, 7'd10);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (n_hs == 4) begin ok = 1'b1; break; end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL abort_reach got=%0b exp=1", ok); end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if ({busy, done, store_intermediate, continue_intermediate} !== 4'b0000) begin
            bad++; $display("FAIL abort_outputs got=%b exp=0000", {busy, done, store_intermediate, continue_intermediate}); end
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++; if (n_done !== 0 || n_wr !== 3 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_quiet got=%0d/%0d/%0b exp=0/3/0", n_done, n_wr, busy); end
        clear_run();
        pulse_start(K2, 32'd0, 7'd4);
        wait_done(500, ok);
        total++; if (ok !== 1'b1 || n_done !== 1) begin bad++; $display("FAIL abort_rerun got=%0b/%0d exp=1/1", ok, n_done); end
        total++; if (n_store !== 1 || store_log.size() == 0 || store_log[0] !== 1'b1) begin
            bad++; $display("FAIL abort_restore got=%0d exp=1", n_store); end
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[i] !== fake(K2, 32'(i))) begin bad++; $display("FAIL abort_mem[%0d] got=%h", i, mem[i]); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] exp_idx;
        clear_run();
        pulse_start(K1, 32'hFFFF_FFFE, 7'd3);
        wait_done(500, ok);
        total++; if (ok !== 1'b1 || n_done !== 1) begin bad++; $display("FAIL wrap_done got=%0b/%0d exp=1/1", ok, n_done); end
        total++; if (idx_log.size() !== 3) begin bad++; $display("FAIL wrap_hash_count got=%0d exp=3", idx_log.size()); end
        for (int i = 0; i < 3; i++) begin
            exp_idx = 32'hFFFF_FFFE + 32'(i);
            total++; if (i < idx_log.size() && idx_log[i] !== exp_idx) begin
                bad++; $display("FAIL wrap_idx[%0d] got=%h exp=%h", i, idx_log[i], exp_idx); end
            total++; if (mem[i] !== fake(K1, exp_idx)) begin bad++; $display("FAIL wrap_mem[%0d] got=%h", i, mem[i]); end
        end
    endtask

    task automatic test_reset_midrun();
        clear_run();
        pulse_start(K2, 32'd5, 7'd6);
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if ({busy, hash_start, seed_mem_wr_en, store_intermediate, continue_intermediate} !== 5'b0) begin
            bad++; $display("FAIL midreset_outputs got=%b exp=00000",
                            {busy, hash_start, seed_mem_wr_en, store_intermediate, continue_intermediate}); end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (busy !== 1'b0 || n_done !== 0) begin bad++; $display("FAIL midreset_quiet got=%0b/%0d exp=0/0", busy, n_done); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_window();
        test_zero_count();
        test_stall();
        test_abort();
        test_wrap();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
